// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler for the shared sample ROM.
// Latches one-cycle trigger pulses as sticky requests, grants the lowest-index
// request, steps the ROM address once per sample period and forwards each
// ROM sample (scaled by 256) to the audio codec interface.
module sfx_scheduler #(
    parameter int NUM_SFX    = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 24,
    parameter int SAMPLE_DIV = 1134,
    parameter logic [NUM_SFX*ADDR_W-1:0] SFX_BASE = {16'd12288, 16'd8192, 16'd4096, 16'd0},
    parameter logic [NUM_SFX*ADDR_W-1:0] SFX_LEN  = {16'd4096, 16'd4096, 16'd4096, 16'd4096}
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [NUM_SFX-1:0]         trigger,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [DATA_W-1:0]          rom_q,
    output logic [31:0]                sound,
    output logic                       busy,
    output logic [$clog2(NUM_SFX)-1:0] active_id,
    output logic                       sample_tick
);

    localparam int ID_W  = $clog2(NUM_SFX);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [NUM_SFX-1:0]  pending_reg, pending_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   remaining_reg, remaining_next;
    logic [DIV_W-1:0]    divider_reg, divider_next;
    logic [ID_W-1:0]     id_reg, id_next;
    logic                tick_reg, tick_next;
    logic                q_valid_reg, q_valid_next;
    logic [31:0]         sound_reg, sound_next;

    // Per-effect start address and (length - 1), unpacked from the parameters.
    logic [ADDR_W-1:0]   base_arr   [NUM_SFX];
    logic [ADDR_W-1:0]   len_m1_arr [NUM_SFX];

    logic [ID_W-1:0]     winner_id;
    logic                grant;
    logic [NUM_SFX-1:0]  grant_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SFX; gi++) begin : g_table
            assign base_arr[gi]   = SFX_BASE[gi*ADDR_W +: ADDR_W];
            assign len_m1_arr[gi] = SFX_LEN[gi*ADDR_W +: ADDR_W] - ADDR_W'(1);
        end
    endgenerate

    // Fixed-priority encoder: the lowest-index pending request wins.
    always_comb begin
        winner_id = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                winner_id = ID_W'(i);
            end
        end
    end

    // Next-state logic: grant/preempt, sample stepping, end of effect, sound path.
    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        divider_next   = divider_reg;
        id_next        = id_reg;
        tick_next      = 1'b0;
        q_valid_next   = q_valid_reg;
        sound_next     = sound_reg;
        grant          = 1'b0;
        grant_mask     = '0;

        case (state_reg)
            IDLE: begin
                sound_next   = '0;
                q_valid_next = 1'b0;
                if (pending_reg != '0) begin
                    grant = 1'b1;
                end
            end
            PLAY: begin
                // A request at or above the active priority (including a
                // retrigger of the active effect) takes over immediately.
                if ((pending_reg != '0) && (winner_id <= id_reg)) begin
                    grant = 1'b1;
                end else begin
                    // rom_q only carries this effect's data from the second
                    // PLAY cycle on; hold sound at 0 until then.
                    q_valid_next = 1'b1;
                    sound_next   = q_valid_reg ? 32'({rom_q, 8'h00}) : 32'd0;
                    if (divider_reg == '0) begin
                        if (remaining_reg != '0) begin
                            addr_next      = addr_reg + ADDR_W'(1);
                            remaining_next = remaining_reg - ADDR_W'(1);
                            divider_next   = DIV_RELOAD;
                            tick_next      = 1'b1;
                        end else begin
                            state_next   = IDLE;
                            sound_next   = '0;
                            q_valid_next = 1'b0;
                        end
                    end else begin
                        divider_next = divider_reg - DIV_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (grant) begin
            grant_mask     = {{(NUM_SFX-1){1'b0}}, 1'b1} << winner_id;
            addr_next      = base_arr[winner_id];
            remaining_next = len_m1_arr[winner_id];
            divider_next   = DIV_RELOAD;
            id_next        = winner_id;
            state_next     = PLAY;
            sound_next     = '0;
            q_valid_next   = 1'b0;
            tick_next      = 1'b0;
        end

        // A trigger arriving together with its own grant stays pending.
        pending_next = (pending_reg & ~grant_mask) | trigger;
    end

    // State and datapath registers; reset aborts playback at once.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            divider_reg   <= '0;
            id_reg        <= '0;
            tick_reg      <= 1'b0;
            q_valid_reg   <= 1'b0;
            sound_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            divider_reg   <= divider_next;
            id_reg        <= id_next;
            tick_reg      <= tick_next;
            q_valid_reg   <= q_valid_next;
            sound_reg     <= sound_next;
        end
    end

    assign rom_addr    = addr_reg;
    assign sound       = sound_reg;
    assign busy        = (state_reg == PLAY);
    assign active_id   = id_reg;
    assign sample_tick = tick_reg;

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
- Sequences the single shared sound-effect sample ROM: a 24-bit data, 16-bit address, 1-cycle read latency instance of musicRom.
- Accepts one-cycle trigger pulses from up to NUM_SFX game events (landing, damage, death, menu), arbitrates them by fixed priority and plays one effect at a time.
- Steps the ROM address at the audio sample rate and drives the scaled 32-bit sample to the audio codec interface.

Parameters:
- NUM_SFX, 4, number of trigger sources; index 0 is highest priority.
- ADDR_W, 16, ROM address width.
- DATA_W, 24, ROM sample width.
- SAMPLE_DIV, 1134, CLOCK_50 cycles per sample (≈44.1 kHz); must be ≥ 3.
- SFX_BASE, packed NUM_SFX*ADDR_W, start address of each effect; effect i occupies slice [i*ADDR_W +: ADDR_W].
- SFX_LEN, packed NUM_SFX*ADDR_W, length in samples of each effect; must be ≥ 1.

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- trigger  in  NUM_SFX  one-cycle request pulses, one bit per effect
- rom_addr  out  ADDR_W  address to musicRom
- rom_q  in  DATA_W  musicRom data; valid 1 cycle after rom_addr is clocked in
- sound  out  32  current sample, equal to rom_q*256; 0 when idle
- busy  out  1  high while in PLAY
- active_id  out  clog2(NUM_SFX)  index of the playing effect
- sample_tick  out  1  one-cycle pulse on each address advance

Behaviour:
- Reset (async, resetn=0): state IDLE; pending=0, rom_addr=0, sound=0, busy=0, active_id=0, sample_tick=0, divider=0, remaining=0.
- Pending register: each trigger bit sets a sticky pending bit on the clock edge. A bit is cleared only when that effect is granted. A trigger arriving on the same cycle as its grant stays set, so the effect plays again afterwards.
- Grant rule: the lowest-index pending bit wins.
- IDLE: if pending≠0, grant winner g on this edge:
  - rom_addr=SFX_BASE[g], remaining=SFX_LEN[g]-1, divider=SAMPLE_DIV-1
  - active_id=g, busy=1, state PLAY
- PLAY, no preemption:
  - Divider decrements every cycle.
  - When divider==0 and remaining≠0: rom_addr+1, remaining-1, divider reloads to SAMPLE_DIV-1, sample_tick=1 for that cycle.
  - When divider==0 and remaining==0: effect ends; state IDLE, busy=0, sound forced to 0 on the same edge.
- Preemption: in PLAY, if a pending bit with index < active_id exists, or the active effect's own bit is pending (retrigger), the grant sequence above is applied immediately on the next edge, regardless of divider.
  - Lower-priority pending effects wait; they are not dropped.
  - The preempted effect is abandoned, not resumed.
- After an effect ends, a pending request is granted on the following edge (one IDLE cycle).
- Sound path: sound <= {rom_q, 8'b0}, updated every cycle in PLAY. The first valid sample of an effect appears 2 cycles after rom_addr loads (ROM latency 1 + output register 1). While in PLAY, sound is 0 until that first valid sample.
- Width rules: remaining and divider are unsigned. rom_addr wraps modulo 2^ADDR_W; effects must not cross the top of the ROM.
- Simultaneous events: a tick and a preemption in the same cycle resolve as preemption. Reset mid-play aborts immediately with all outputs 0.

Test Plan:
- Setup: SAMPLE_DIV=4, SFX_BASE={300,200,100,0}, SFX_LEN={5,4,3,2}.
- Reset, then trigger[2] pulse → busy=1, rom_addr=200 next edge, then 201,202,203 every 4 cycles with sample_tick pulses; busy drops 4 cycles after addr 203; sound=rom_q*256 lagging 2 cycles.
- trigger[3] during playback of effect 1 → effect 1 completes all 3 samples (100..102); after 1 IDLE cycle rom_addr=300, active_id=3.
- trigger[0] while effect 2 is at addr 201 → next edge rom_addr=0, active_id=0; effect 2 is not resumed.
- trigger[1] retrigger while effect 1 is at addr 102 → rom_addr returns to 100; the effect replays fully.
- trigger=4'b1111 in one cycle → effects 0,1,2,3 play back to back in order, each separated by one IDLE cycle; sound=0 in each gap.
- resetn low mid-play at addr 202 → asynchronously: busy=0, sound=0, rom_addr=0, pending cleared; no playback after release.
